// File: rtl/seq_gen.sv
// Serial pattern transmitter: shifts a latched word out MSB-first, one bit per
// 2^DIV_W clk cycles, with optional seamless repeat of the same pattern.
module seq_gen #(
  parameter int DIV_W  = 28,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              rep_i,
  output logic              dout_o,
  output logic              busy_o,
  output logic              ready_o,
  output logic              done_o,
  output logic              bit_tick_o
);

  // state | meaning
  // IDLE  | waiting for load, dout low, divider held at 0
  // SEND  | shifting the pattern out, one bit per divider wrap
  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              dout_q, dout_d;
  logic              done_q, done_d;
  logic [LEN_W-1:0]  len_clamp;
  logic              tick;

  assign len_clamp = (len_i == '0 || len_i > LEN_MAX) ? LEN_MAX : len_i;
  assign tick      = (state_q == SEND) && (div_q == '1);

  always_comb begin
    state_d = state_q;
    div_d   = '0;
    cnt_d   = cnt_q;
    len_d   = len_q;
    shift_d = shift_q;
    word_d  = word_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_i) begin
          len_d   = len_clamp;
          word_d  = data_i;
          // left-justify so data[L-1] is the first bit out
          shift_d = data_i << (LEN_MAX - len_clamp);
          cnt_d   = len_clamp - LEN_W'(1);
          state_d = SEND;
        end
      end
      SEND: begin
        div_d = div_q + DIV_W'(1);
        if (tick) begin
          if (cnt_q != '0) begin
            shift_d = shift_q << 1;
            cnt_d   = cnt_q - LEN_W'(1);
          end else if (rep_i) begin
            shift_d = word_q << (LEN_MAX - len_q);
            cnt_d   = len_q - LEN_W'(1);
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    dout_d = (state_d == SEND) ? shift_d[DATA_W-1] : 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      dout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  assign dout_o     = dout_q;
  assign busy_o     = (state_q == SEND);
  assign ready_o    = (state_q != SEND);
  assign done_o     = done_q;
  assign bit_tick_o = tick;

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: queue-based stream model checked every cycle, plus
// directed scenarios with literal expectations on the serial stream.
module tb_seq_gen;

  localparam int DIV_W  = 2;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;
  localparam int PER    = 1 << DIV_W;

  logic             clk, rst_n, load, rep;
  logic [DATA_W-1:0] data;
  logic [LEN_W-1:0]  len;
  logic dout, busy, ready, done, tick;

  seq_gen #(.DIV_W(DIV_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .load_i(load), .data_i(data), .len_i(len),
    .rep_i(rep), .dout_o(dout), .busy_o(busy), .ready_o(ready),
    .done_o(done), .bit_tick_o(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: each accepted pattern expands into one queue entry per clk cycle.
  typedef struct packed {logic b; logic tk; logic last;} ent_t;
  ent_t q[$];
  logic [DATA_W-1:0] m_word;
  int   m_len;
  logic m_done;

  task automatic push_pass(input logic [DATA_W-1:0] w, input int l);
    ent_t e;
    for (int k = l - 1; k >= 0; k--)
      for (int c = 0; c < PER; c++) begin
        e.b = w[k];
        e.tk = (c == PER - 1);
        e.last = (k == 0) && (c == PER - 1);
        q.push_back(e);
      end
  endtask

  always @(posedge clk or negedge rst_n) begin
    ent_t e;
    if (!rst_n) begin
      q.delete();
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.last) begin
          if (rep) push_pass(m_word, m_len);
          else m_done = 1'b1;
        end
      end else if (load) begin
        m_word = data;
        m_len  = (len == 0 || int'(len) > DATA_W) ? DATA_W : int'(len);
        push_pass(m_word, m_len);
      end
    end
  end

  always @(negedge clk) begin
    logic eb;
    if (rst_n) begin
      eb = (q.size() != 0);
      chk("busy",  32'(busy),  32'(eb));
      chk("ready", 32'(ready), 32'(!eb));
      chk("dout",  32'(dout),  eb ? 32'(q[0].b) : 32'd0);
      chk("tick",  32'(tick),  eb ? 32'(q[0].tk) : 32'd0);
      chk("done",  32'(done),  32'(m_done));
    end
  end

  int busy_cnt, done_cnt, tick_cnt;
  logic [31:0] cap;
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (tick) begin
        tick_cnt++;
        cap = {cap[30:0], dout};
      end
    end
  end

  task automatic clr();
    busy_cnt = 0; done_cnt = 0; tick_cnt = 0; cap = '0;
  endtask

  task automatic do_load(input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] l, input logic r);
    @(posedge clk); #1;
    load = 1'b1; data = d; len = l; rep = r;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic expect_run(input string nm, input logic [31:0] bits, input int b_cyc,
                            input int ticks, input int dones);
    chk({nm, "_bits"},  cap,               bits);
    chk({nm, "_busy"},  32'(busy_cnt),     32'(b_cyc));
    chk({nm, "_ticks"}, 32'(tick_cnt),     32'(ticks));
    chk({nm, "_done"},  32'(done_cnt),     32'(dones));
    chk({nm, "_dout0"}, 32'(dout),         32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; load = 1'b0; data = '0; len = '0; rep = 1'b0;
    clr();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_dout",  32'(dout),  32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done",  32'(done),  32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    clr(); do_load(8'h15, 4'd5, 1'b0); wait_idle(200);
    expect_run("basic", 32'h15, 20, 5, 1);

    clr(); do_load(8'hA5, 4'd0, 1'b0); wait_idle(200);
    expect_run("clamp0", 32'hA5, 32, 8, 1);

    clr(); do_load(8'hA5, 4'd12, 1'b0); wait_idle(200);
    expect_run("clamp12", 32'hA5, 32, 8, 1);

    clr(); do_load(8'h05, 4'd3, 1'b1);
    repeat (28) @(posedge clk);
    #1 rep = 1'b0;
    wait_idle(200);
    expect_run("repeat", 32'h16D, 36, 9, 1);

    clr(); do_load(8'h15, 4'd5, 1'b0);
    repeat (6) @(posedge clk);
    #1 load = 1'b1; data = 8'h00; len = 4'd5;
    @(posedge clk); #1 load = 1'b0; data = 8'hFF;
    wait_idle(200);
    repeat (10) @(negedge clk);
    expect_run("busyload", 32'h15, 20, 5, 1);

    clr(); do_load(8'h15, 4'd5, 1'b0);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", 32'(done), 32'd1);
    load = 1'b1; data = 8'h01; len = 4'd1;
    @(posedge clk); #1 load = 1'b0;
    @(negedge clk);
    chk("b2b_busy_next", 32'(busy), 32'd1);
    chk("b2b_dout_next", 32'(dout), 32'd1);
    wait_idle(200);
    expect_run("b2b", 32'h2B, 24, 6, 2);

    clr(); do_load(8'hFF, 4'd8, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_dout",  32'(dout),  32'd0);
    chk("abort_busy",  32'(busy),  32'd0);
    chk("abort_done",  32'(done),  32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    clr();
    repeat (40) @(negedge clk);
    chk("abort_nodone", 32'(done_cnt), 32'd0);
    chk("abort_nobusy", 32'(busy_cnt), 32'd0);
    chk("abort_ready2", 32'(ready),    32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
